// File: rtl/traffic_light_ctrl.sv
// Traffic-light controller: RED/GREEN/YELLOW phases timed in 1 s ticks,
// pedestrian-shortened green, flashing-yellow night mode, countdown output.
// Ports: clk, rst (sync, active-high), en, night_mode, ped_req in;
//        led {yellow,green,red}, ped_walk, remain, tick out.
module traffic_light_ctrl #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int CNT_W    = 8,
  parameter int RED_T    = 5,
  parameter int GREEN_T  = 3,
  parameter int YELLOW_T = 1,
  parameter int PED_T    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic [2:0]       led,
  output logic             ped_walk,
  output logic [CNT_W-1:0] remain,
  output logic             tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0]    PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RED_L   = CNT_W'(RED_T);
  localparam logic [CNT_W-1:0] GRN_L   = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YEL_L   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] PED_L   = CNT_W'(PED_T);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RED    = 3'd1,
    S_GREEN  = 3'd2,
    S_YELLOW = 3'd3,
    S_FLASH  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [2:0]       led_q, led_d;
  logic             walk_q, walk_d;
  logic             pend_q, pend_d;
  logic             flash_q, flash_d;
  logic             tick_w;

  assign tick_w   = en && (presc_q == PRE_MAX);
  assign tick     = tick_w;
  assign led      = led_q;
  assign ped_walk = walk_q;
  assign remain   = remain_q;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    pend_d   = pend_q;
    flash_d  = flash_q;

    // Prescaler stays at 0 in IDLE so the first RED phase is full length.
    if (en) begin
      if (tick_w || state_q == S_IDLE) presc_d = '0;
      else presc_d = presc_q + 1'b1;
    end

    if (ped_req && (state_q == S_GREEN || state_q == S_YELLOW))
      pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d  = S_RED;
          remain_d = RED_L;
        end
      end
      S_RED, S_GREEN, S_YELLOW: begin
        if (tick_w) begin
          if (remain_q > ONE) begin
            remain_d = remain_q - ONE;
          end else if (night_mode) begin
            state_d  = S_FLASH;
            remain_d = '0;
            flash_d  = 1'b0;
            pend_d   = 1'b0;
          end else begin
            case (state_q)
              S_RED: begin
                state_d  = S_GREEN;
                remain_d = GRN_L;
              end
              S_GREEN: begin
                state_d  = S_YELLOW;
                remain_d = YEL_L;
              end
              default: begin
                state_d  = S_RED;
                remain_d = RED_L;
                pend_d   = 1'b0;
              end
            endcase
          end
        end else if (en && state_q == S_GREEN &&
                     pend_q && remain_q > PED_L) begin
          // Clamp only on non-tick cycles; a coinciding tick decrements first.
          remain_d = PED_L;
        end
      end
      S_FLASH: begin
        if (tick_w) begin
          if (night_mode) begin
            flash_d = ~flash_q;
          end else begin
            state_d  = S_RED;
            remain_d = RED_L;
            flash_d  = 1'b0;
            pend_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        presc_d  = '0;
        remain_d = '0;
        flash_d  = 1'b0;
        pend_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    led_d  = 3'b000;
    walk_d = 1'b0;
    case (state_q)
      S_RED: begin
        led_d  = 3'b001;
        walk_d = 1'b1;
      end
      S_GREEN:  led_d = 3'b010;
      S_YELLOW: led_d = 3'b100;
      S_FLASH:  led_d = {flash_q, 2'b00};
      default:  led_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      remain_q <= '0;
      led_q    <= 3'b000;
      walk_q   <= 1'b0;
      pend_q   <= 1'b0;
      flash_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      led_q    <= led_d;
      walk_q   <= walk_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with CLK_DIV=4, RED/GREEN/YELLOW=5/3/1.
// Checks are sampled 1 time unit after each rising edge.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       night_mode;
  logic       ped_req;
  logic [2:0] led;
  logic       ped_walk;
  logic [7:0] remain;
  logic       tick;

  int n_run  = 0;
  int n_fail = 0;

  traffic_light_ctrl #(
    .CLK_DIV (4),
    .CNT_W   (8),
    .RED_T   (5),
    .GREEN_T (3),
    .YELLOW_T(1),
    .PED_T   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .night_mode(night_mode),
    .ped_req   (ped_req),
    .led       (led),
    .ped_walk  (ped_walk),
    .remain    (remain),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    night_mode = 1'b0;
    ped_req = 1'b0;

    cyc(2);
    chk("rst_led", led, 3'b000);
    chk("rst_remain", remain, 0);
    chk("rst_walk", ped_walk, 0);
    chk("rst_tick", tick, 0);

    en = 1'b1;
    cyc(1);
    chk("rst_ovr_led", led, 3'b000);
    chk("rst_ovr_remain", remain, 0);
    rst = 1'b0;

    cyc(1);
    chk("a1_led", led, 3'b000);
    chk("a1_remain", remain, 5);
    chk("a1_tick", tick, 0);
    cyc(1);
    chk("a2_led", led, 3'b001);
    chk("a2_walk", ped_walk, 1);
    cyc(2);
    chk("a4_tick", tick, 1);
    chk("a4_remain", remain, 5);
    cyc(1);
    chk("a5_tick", tick, 0);
    chk("a5_remain", remain, 4);
    cyc(15);
    chk("a20_remain", remain, 1);
    chk("a20_tick", tick, 1);
    cyc(1);
    chk("a21_remain", remain, 3);
    chk("a21_led", led, 3'b001);
    ped_req = 1'b1;
    cyc(1);
    ped_req = 1'b0;
    chk("a22_led", led, 3'b010);
    chk("a22_walk", ped_walk, 0);
    chk("a22_remain", remain, 3);
    cyc(1);
    chk("ped_clamp", remain, 1);
    cyc(1);
    chk("a24_tick", tick, 1);
    chk("a24_remain", remain, 1);
    cyc(1);
    chk("yel_remain", remain, 1);
    chk("yel_led_lag", led, 3'b010);
    cyc(1);
    chk("yel_led", led, 3'b100);
    cyc(3);
    chk("red2_remain", remain, 5);
    chk("red2_led_lag", led, 3'b100);
    cyc(1);
    chk("red2_led", led, 3'b001);
    chk("red2_walk", ped_walk, 1);
    cyc(21);
    chk("grn2_no_clamp", remain, 3);
    chk("grn2_led", led, 3'b010);
    cyc(2);
    chk("grn2_remain2", remain, 2);
    cyc(3);
    chk("pre_frz_tick", tick, 1);
    chk("pre_frz_remain", remain, 2);
    en = 1'b0;
    #1;
    chk("frz_tick_gate", tick, 0);
    cyc(10);
    chk("frz_remain", remain, 2);
    chk("frz_led", led, 3'b010);
    chk("frz_tick", tick, 0);
    en = 1'b1;
    #1;
    chk("resume_tick", tick, 1);
    cyc(1);
    chk("r1_remain", remain, 1);
    chk("r1_tick", tick, 0);
    cyc(3);
    chk("r4_tick", tick, 1);
    chk("r4_led", led, 3'b010);
    cyc(1);
    chk("r5_remain", remain, 1);
    chk("r5_led", led, 3'b010);
    cyc(1);
    chk("r6_led", led, 3'b100);

    rst = 1'b1;
    cyc(1);
    chk("mid_rst_led", led, 3'b000);
    chk("mid_rst_remain", remain, 0);
    chk("mid_rst_walk", ped_walk, 0);
    rst = 1'b0;
    cyc(1);
    chk("c1_remain", remain, 5);
    chk("c1_led", led, 3'b000);
    cyc(1);
    chk("c2_led", led, 3'b001);
    cyc(8);
    night_mode = 1'b1;
    cyc(10);
    chk("c20_remain", remain, 1);
    chk("c20_led", led, 3'b001);
    cyc(1);
    chk("flash_remain", remain, 0);
    chk("c21_led", led, 3'b001);
    cyc(1);
    chk("flash_led0", led, 3'b000);
    chk("flash_walk", ped_walk, 0);
    ped_req = 1'b1;
    cyc(3);
    chk("c25_led", led, 3'b000);
    chk("c25_remain", remain, 0);
    cyc(1);
    chk("flash_led1", led, 3'b100);
    cyc(3);
    chk("c29_led", led, 3'b100);
    cyc(1);
    chk("flash_led2", led, 3'b000);
    night_mode = 1'b0;
    cyc(2);
    chk("c32_tick", tick, 1);
    chk("c32_remain", remain, 0);
    cyc(1);
    chk("exit_remain", remain, 5);
    chk("c33_led", led, 3'b000);
    cyc(1);
    chk("c34_led", led, 3'b001);
    chk("c34_walk", ped_walk, 1);
    cyc(19);
    chk("c53_remain", remain, 3);
    chk("c53_led", led, 3'b001);
    ped_req = 1'b0;
    cyc(2);
    chk("held_no_pend", remain, 3);
    chk("c55_led", led, 3'b010);
    ped_req = 1'b1;
    cyc(1);
    chk("c56_tick", tick, 1);
    chk("c56_remain", remain, 3);
    ped_req = 1'b0;
    cyc(1);
    chk("tick_dec_wins", remain, 2);
    cyc(1);
    chk("clamp_after", remain, 1);
    cyc(3);
    chk("c61_remain", remain, 1);
    chk("c61_led", led, 3'b010);
    cyc(1);
    chk("c62_led", led, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
